// File: rtl/decode_pipe_ctrl.sv
// RV32I(+M) instruction decoder registered behind a 2-entry skid buffer.
// Exports a control bundle to EX and raises the load-use interlock.
module decode_pipe_ctrl #(
    parameter int INST_WIDTH     = 32,
    parameter int PC_WIDTH       = 32,
    parameter int ENABLE_M       = 0,
    parameter int LOAD_INTERLOCK = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INST_WIDTH-1:0] in_inst,
    input  logic [PC_WIDTH-1:0]   in_pc,
    input  logic                  flush,
    input  logic                  ex_load_valid,
    input  logic [4:0]            ex_load_rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PC_WIDTH-1:0]   out_pc,
    output logic [INST_WIDTH-1:0] out_inst,
    output logic [4:0]            rd,
    output logic [4:0]            rs1,
    output logic [4:0]            rs2,
    output logic                  reg_write,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  is_load,
    output logic                  is_store,
    output logic                  is_branch,
    output logic                  is_jump,
    output logic                  is_system,
    output logic                  is_csr,
    output logic                  has_imm,
    output logic                  illegal,
    output logic [1:0]            mem_size,
    output logic                  mem_unsigned,
    output logic [4:0]            alu_op,
    output logic [2:0]            imm_type,
    output logic [1:0]            pc_sel,
    output logic [2:0]            br_cond,
    output logic                  hazard
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [4:0] ALU_ADD    = 5'h00;
    localparam logic [4:0] ALU_SUB    = 5'h01;
    localparam logic [4:0] ALU_AND    = 5'h02;
    localparam logic [4:0] ALU_OR     = 5'h03;
    localparam logic [4:0] ALU_XOR    = 5'h04;
    localparam logic [4:0] ALU_SLL    = 5'h07;
    localparam logic [4:0] ALU_SRL    = 5'h08;
    localparam logic [4:0] ALU_SRA    = 5'h09;
    localparam logic [4:0] ALU_SLT    = 5'h0A;
    localparam logic [4:0] ALU_SLTU   = 5'h0B;
    localparam logic [4:0] ALU_PASS_A = 5'h0C;
    localparam logic [4:0] ALU_PASS_B = 5'h0D;
    localparam logic [4:0] ALU_EQ     = 5'h0F;
    localparam logic [4:0] ALU_MUL    = 5'h11;

    localparam logic [2:0] IMM_I     = 3'd0;
    localparam logic [2:0] IMM_SHIFT = 3'd1;
    localparam logic [2:0] IMM_S     = 3'd2;
    localparam logic [2:0] IMM_U     = 3'd3;
    localparam logic [2:0] IMM_B     = 3'd4;
    localparam logic [2:0] IMM_J     = 3'd5;

    typedef struct packed {
        logic [PC_WIDTH-1:0]   pc;
        logic [INST_WIDTH-1:0] inst;
        logic [4:0]            rd;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  is_load;
        logic                  is_store;
        logic                  is_branch;
        logic                  is_jump;
        logic                  is_system;
        logic                  is_csr;
        logic                  has_imm;
        logic                  illegal;
        logic [1:0]            mem_size;
        logic                  mem_unsigned;
        logic [4:0]            alu_op;
        logic [2:0]            imm_type;
        logic [1:0]            pc_sel;
        logic [2:0]            br_cond;
        logic                  rs1_used;
        logic                  rs2_used;
    } bundle_t;

    // funct3 -> ALU op for the shared OP / OP-IMM table (funct7 = 0 flavour)
    function automatic logic [4:0] base_alu(input logic [2:0] f3);
        case (f3)
            3'd0:    base_alu = ALU_ADD;
            3'd1:    base_alu = ALU_SLL;
            3'd2:    base_alu = ALU_SLT;
            3'd3:    base_alu = ALU_SLTU;
            3'd4:    base_alu = ALU_XOR;
            3'd5:    base_alu = ALU_SRL;
            3'd6:    base_alu = ALU_OR;
            default: base_alu = ALU_AND;
        endcase
    endfunction

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       dec_wr;
    logic       dec_ill;
    bundle_t    dec_p0;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];

    // ---- stage 0: combinational decode of the incoming word ----
    always_comb begin
        dec_p0          = '0;
        dec_wr          = 1'b0;
        dec_ill         = 1'b0;
        dec_p0.pc       = in_pc;
        dec_p0.inst     = in_inst;
        dec_p0.rd       = in_inst[11:7];
        dec_p0.rs1      = in_inst[19:15];
        dec_p0.rs2      = in_inst[24:20];
        dec_p0.rs1_used = 1'b1;
        case (opcode)
            OPC_LUI: begin
                dec_p0.alu_op   = ALU_PASS_B;
                dec_p0.imm_type = IMM_U;
                dec_p0.has_imm  = 1'b1;
                dec_p0.rs1_used = 1'b0;
                dec_wr          = 1'b1;
            end
            OPC_AUIPC: begin
                dec_p0.alu_op   = ALU_ADD;
                dec_p0.imm_type = IMM_U;
                dec_p0.has_imm  = 1'b1;
                dec_p0.rs1_used = 1'b0;
                dec_wr          = 1'b1;
            end
            OPC_JAL: begin
                dec_p0.alu_op   = ALU_PASS_A;
                dec_p0.imm_type = IMM_J;
                dec_p0.pc_sel   = 2'd2;
                dec_p0.is_jump  = 1'b1;
                dec_p0.has_imm  = 1'b1;
                dec_p0.rs1_used = 1'b0;
                dec_wr          = 1'b1;
            end
            OPC_JALR: begin
                dec_p0.alu_op   = ALU_PASS_A;
                dec_p0.imm_type = IMM_I;
                dec_p0.pc_sel   = 2'd3;
                dec_p0.is_jump  = 1'b1;
                dec_p0.has_imm  = 1'b1;
                dec_wr          = 1'b1;
                dec_ill         = (funct3 != 3'd0);
            end
            OPC_BRANCH: begin
                dec_p0.alu_op    = ALU_EQ;
                dec_p0.imm_type  = IMM_B;
                dec_p0.pc_sel    = 2'd1;
                dec_p0.is_branch = 1'b1;
                dec_p0.br_cond   = funct3;
                dec_p0.rs2_used  = 1'b1;
                dec_ill          = (funct3 == 3'd2) || (funct3 == 3'd3);
            end
            OPC_LOAD: begin
                dec_p0.alu_op       = ALU_ADD;
                dec_p0.imm_type     = IMM_I;
                dec_p0.has_imm      = 1'b1;
                dec_p0.is_load      = 1'b1;
                dec_p0.mem_size     = funct3[1:0];
                dec_p0.mem_unsigned = funct3[2];
                dec_wr              = 1'b1;
                dec_ill             = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
            end
            OPC_STORE: begin
                dec_p0.alu_op       = ALU_ADD;
                dec_p0.imm_type     = IMM_S;
                dec_p0.has_imm      = 1'b1;
                dec_p0.is_store     = 1'b1;
                dec_p0.mem_size     = funct3[1:0];
                dec_p0.mem_unsigned = funct3[2];
                dec_p0.rs2_used     = 1'b1;
                dec_ill             = (funct3 > 3'd2);
            end
            OPC_OP_IMM: begin
                dec_p0.has_imm = 1'b1;
                dec_p0.alu_op  = base_alu(funct3);
                dec_wr         = 1'b1;
                if (funct3 == 3'd1) begin
                    dec_p0.imm_type = IMM_SHIFT;
                    dec_ill         = (funct7 != 7'h00);
                end else if (funct3 == 3'd5) begin
                    dec_p0.imm_type = IMM_SHIFT;
                    if (funct7 == 7'h20) dec_p0.alu_op = ALU_SRA;
                    dec_ill = (funct7 != 7'h00) && (funct7 != 7'h20);
                end
            end
            OPC_OP: begin
                dec_p0.rs2_used = 1'b1;
                dec_wr          = 1'b1;
                if (funct7 == 7'h00)
                    dec_p0.alu_op = base_alu(funct3);
                else if (funct7 == 7'h20 && funct3 == 3'd0)
                    dec_p0.alu_op = ALU_SUB;
                else if (funct7 == 7'h20 && funct3 == 3'd5)
                    dec_p0.alu_op = ALU_SRA;
                else if (funct7 == 7'h01 && ENABLE_M != 0)
                    dec_p0.alu_op = ALU_MUL + {2'b00, funct3};
                else
                    dec_ill = 1'b1;
            end
            OPC_FENCE: begin
            end
            OPC_SYSTEM: begin
                dec_p0.is_system = 1'b1;
                if (funct3 != 3'd0) begin
                    dec_p0.is_csr  = 1'b1;
                    dec_p0.alu_op  = ALU_PASS_B;
                    dec_p0.has_imm = funct3[2];
                    dec_wr         = 1'b1;
                end
            end
            default: dec_ill = 1'b1;
        endcase
        // illegal words still flow to EX but must not touch state
        dec_p0.illegal   = dec_ill;
        dec_p0.reg_write = dec_wr && !dec_ill && (in_inst[11:7] != 5'd0);
        dec_p0.mem_read  = dec_p0.is_load && !dec_ill;
        dec_p0.mem_write = dec_p0.is_store && !dec_ill;
    end

    bundle_t o_p1;
    bundle_t s_p1;
    logic    o_vld_p1;
    logic    s_vld_p1;
    logic    accept;
    logic    fire;
    logic    o_free;
    logic    haz_match;

    assign in_ready = !rst && !s_vld_p1;
    assign accept   = in_valid && in_ready;
    assign haz_match = (ex_load_rd != 5'd0) &&
                       ((o_p1.rs1_used && (ex_load_rd == o_p1.rs1)) ||
                        (o_p1.rs2_used && (ex_load_rd == o_p1.rs2)));
    assign hazard    = (LOAD_INTERLOCK != 0) && !rst && o_vld_p1 && ex_load_valid && haz_match;
    assign out_valid = !rst && o_vld_p1 && !hazard;
    assign fire      = out_valid && out_ready;
    assign o_free    = !o_vld_p1 || fire;

    // ---- stage 1: output register O with skid register S behind it ----
    always_ff @(posedge clk) begin
        if (rst) begin
            o_vld_p1 <= 1'b0;
            s_vld_p1 <= 1'b0;
            o_p1     <= '0;
            s_p1     <= '0;
        end else if (flush) begin
            o_vld_p1 <= 1'b0;
            s_vld_p1 <= 1'b0;
        end else if (o_free) begin
            if (s_vld_p1) begin
                o_p1     <= s_p1;
                o_vld_p1 <= 1'b1;
                s_vld_p1 <= 1'b0;
            end else begin
                o_vld_p1 <= accept;
                if (accept) o_p1 <= dec_p0;
            end
        end else if (accept) begin
            s_p1     <= dec_p0;
            s_vld_p1 <= 1'b1;
        end
    end

    assign out_pc       = o_p1.pc;
    assign out_inst     = o_p1.inst;
    assign rd           = o_p1.rd;
    assign rs1          = o_p1.rs1;
    assign rs2          = o_p1.rs2;
    assign reg_write    = o_p1.reg_write;
    assign mem_read     = o_p1.mem_read;
    assign mem_write    = o_p1.mem_write;
    assign is_load      = o_p1.is_load;
    assign is_store     = o_p1.is_store;
    assign is_branch    = o_p1.is_branch;
    assign is_jump      = o_p1.is_jump;
    assign is_system    = o_p1.is_system;
    assign is_csr       = o_p1.is_csr;
    assign has_imm      = o_p1.has_imm;
    assign illegal      = o_p1.illegal;
    assign mem_size     = o_p1.mem_size;
    assign mem_unsigned = o_p1.mem_unsigned;
    assign alu_op       = o_p1.alu_op;
    assign imm_type     = o_p1.imm_type;
    assign pc_sel       = o_p1.pc_sel;
    assign br_cond      = o_p1.br_cond;

endmodule

// File: tb/tb_decode_pipe_ctrl.sv
// Bench for decode_pipe_ctrl: two instances (M off / M on) driven in lockstep,
// directed scenarios followed by a random stream checked against a queue model.
module tb_decode_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        ex_load_valid = 1'b0;
    logic [4:0]  ex_load_rd = '0;
    logic        out_ready = 1'b0;

    logic        in_ready_0, out_valid_0, hazard_0, in_ready_1, out_valid_1, hazard_1;
    logic [31:0] out_pc_0, out_inst_0, out_pc_1, out_inst_1;
    logic [4:0]  rd_0, rs1_0, rs2_0, alu_op_0, rd_1, rs1_1, rs2_1, alu_op_1;
    logic        reg_write_0, mem_read_0, mem_write_0, is_load_0, is_store_0, is_branch_0;
    logic        is_jump_0, is_system_0, is_csr_0, has_imm_0, illegal_0, mem_unsigned_0;
    logic        reg_write_1, mem_read_1, mem_write_1, is_load_1, is_store_1, is_branch_1;
    logic        is_jump_1, is_system_1, is_csr_1, has_imm_1, illegal_1, mem_unsigned_1;
    logic [1:0]  mem_size_0, pc_sel_0, mem_size_1, pc_sel_1;
    logic [2:0]  imm_type_0, br_cond_0, imm_type_1, br_cond_1;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    decode_pipe_ctrl #(.INST_WIDTH(32), .PC_WIDTH(32), .ENABLE_M(0), .LOAD_INTERLOCK(1)) u_m0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_0), .in_inst(in_inst),
        .in_pc(in_pc), .flush(flush), .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
        .out_valid(out_valid_0), .out_ready(out_ready), .out_pc(out_pc_0), .out_inst(out_inst_0),
        .rd(rd_0), .rs1(rs1_0), .rs2(rs2_0), .reg_write(reg_write_0), .mem_read(mem_read_0),
        .mem_write(mem_write_0), .is_load(is_load_0), .is_store(is_store_0), .is_branch(is_branch_0),
        .is_jump(is_jump_0), .is_system(is_system_0), .is_csr(is_csr_0), .has_imm(has_imm_0),
        .illegal(illegal_0), .mem_size(mem_size_0), .mem_unsigned(mem_unsigned_0),
        .alu_op(alu_op_0), .imm_type(imm_type_0), .pc_sel(pc_sel_0), .br_cond(br_cond_0),
        .hazard(hazard_0));

    decode_pipe_ctrl #(.INST_WIDTH(32), .PC_WIDTH(32), .ENABLE_M(1), .LOAD_INTERLOCK(1)) u_m1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_1), .in_inst(in_inst),
        .in_pc(in_pc), .flush(flush), .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
        .out_valid(out_valid_1), .out_ready(out_ready), .out_pc(out_pc_1), .out_inst(out_inst_1),
        .rd(rd_1), .rs1(rs1_1), .rs2(rs2_1), .reg_write(reg_write_1), .mem_read(mem_read_1),
        .mem_write(mem_write_1), .is_load(is_load_1), .is_store(is_store_1), .is_branch(is_branch_1),
        .is_jump(is_jump_1), .is_system(is_system_1), .is_csr(is_csr_1), .has_imm(has_imm_1),
        .illegal(illegal_1), .mem_size(mem_size_1), .mem_unsigned(mem_unsigned_1),
        .alu_op(alu_op_1), .imm_type(imm_type_1), .pc_sel(pc_sel_1), .br_cond(br_cond_1),
        .hazard(hazard_1));

    logic [41:0] vec_0, vec_1;
    assign vec_0 = {rd_0, rs1_0, rs2_0, reg_write_0, mem_read_0, mem_write_0, is_load_0, is_store_0,
                    is_branch_0, is_jump_0, is_system_0, is_csr_0, has_imm_0, illegal_0, mem_size_0,
                    mem_unsigned_0, alu_op_0, imm_type_0, pc_sel_0, br_cond_0};
    assign vec_1 = {rd_1, rs1_1, rs2_1, reg_write_1, mem_read_1, mem_write_1, is_load_1, is_store_1,
                    is_branch_1, is_jump_1, is_system_1, is_csr_1, has_imm_1, illegal_1, mem_size_1,
                    mem_unsigned_1, alu_op_1, imm_type_1, pc_sel_1, br_cond_1};

    // ALU code for funct3 0..7 of the plain (funct7=0) OP group, 5 bits each
    localparam logic [39:0] ALU_TBL = {5'h02, 5'h03, 5'h08, 5'h04, 5'h0B, 5'h0A, 5'h07, 5'h00};

    function automatic bit uses_rs1(input logic [31:0] i);
        return !(i[6:0] == 7'b0110111 || i[6:0] == 7'b0010111 || i[6:0] == 7'b1101111);
    endfunction

    function automatic bit uses_rs2(input logic [31:0] i);
        return (i[6:0] == 7'b0110011 || i[6:0] == 7'b1100011 || i[6:0] == 7'b0100011);
    endfunction

    function automatic logic [41:0] model(input logic [31:0] i, input bit en_m);
        logic [2:0] f3;
        logic [6:0] f7;
        bit legal, rw, ld, st, br, jmp, sys, csr, hi, uns;
        logic [4:0] alu;
        logic [2:0] imm, bc;
        logic [1:0] pcs, sz;
        f3 = i[14:12]; f7 = i[31:25];
        legal = 1; rw = 0; ld = 0; st = 0; br = 0; jmp = 0; sys = 0; csr = 0; hi = 0; uns = 0;
        alu = 0; imm = 0; bc = 0; pcs = 0; sz = 0;
        case (i[6:0])
            7'b0110111: begin alu = 5'h0D; imm = 3; rw = 1; hi = 1; end
            7'b0010111: begin alu = 5'h00; imm = 3; rw = 1; hi = 1; end
            7'b1101111: begin alu = 5'h0C; imm = 5; pcs = 2; jmp = 1; rw = 1; hi = 1; end
            7'b1100111: begin alu = 5'h0C; imm = 0; pcs = 3; jmp = 1; rw = 1; hi = 1; legal = (f3 == 0); end
            7'b1100011: begin alu = 5'h0F; imm = 4; pcs = 1; br = 1; bc = f3; legal = !(f3 == 2 || f3 == 3); end
            7'b0000011: begin ld = 1; rw = 1; hi = 1; sz = f3[1:0]; uns = f3[2];
                              legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5); end
            7'b0100011: begin st = 1; hi = 1; imm = 2; sz = f3[1:0]; uns = f3[2]; legal = (f3 <= 2); end
            7'b0010011: begin
                rw = 1; hi = 1; alu = ALU_TBL[f3*5 +: 5];
                if (f3 == 1) begin imm = 1; legal = (f7 == 0); end
                if (f3 == 5) begin
                    imm = 1;
                    if (f7 == 7'h20) alu = 5'h09;
                    else if (f7 != 0) legal = 0;
                end
            end
            7'b0110011: begin
                rw = 1;
                if (f7 == 0) alu = ALU_TBL[f3*5 +: 5];
                else if (f7 == 7'h20 && f3 == 0) alu = 5'h01;
                else if (f7 == 7'h20 && f3 == 5) alu = 5'h09;
                else if (f7 == 7'h01 && en_m) alu = 5'h11 + 5'(f3);
                else legal = 0;
            end
            7'b0001111: begin end
            7'b1110011: begin
                sys = 1;
                if (f3 != 0) begin csr = 1; rw = 1; alu = 5'h0D; hi = f3[2]; end
            end
            default: legal = 0;
        endcase
        rw = rw && legal && (i[11:7] != 0);
        return {i[11:7], i[19:15], i[24:20], rw, ld && legal, st && legal, ld, st, br, jmp, sys, csr,
                hi, !legal, sz, uns, alu, imm, pcs, bc};
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] w;
        logic [6:0]  op;
        w = $urandom;
        if ($urandom_range(0, 9) < 8) begin
            case ($urandom_range(0, 10))
                0: op = 7'b0110111;  1: op = 7'b0010111;  2: op = 7'b1101111;
                3: op = 7'b1100111;  4: op = 7'b1100011;  5: op = 7'b0000011;
                6: op = 7'b0100011;  7: op = 7'b0010011;  8: op = 7'b0110011;
                9: op = 7'b1110011;  default: op = 7'b0001111;
            endcase
            w[6:0] = op; w[11:10] = 2'b00; w[19:18] = 2'b00; w[24:23] = 2'b00;
            if (op == 7'b0110011 || op == 7'b0010011)
                case ($urandom_range(0, 3))
                    0: w[31:25] = 7'h00;
                    1: w[31:25] = 7'h20;
                    2: w[31:25] = 7'h01;
                    default: ;
                endcase
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        #1;
        n_total++; if (in_ready_0 !== 1'b0) $display("FAIL rst_in_ready got=%b want=0", in_ready_0); else n_pass++;
        n_total++; if (out_valid_0 !== 1'b0) $display("FAIL rst_out_valid got=%b want=0", out_valid_0); else n_pass++;
        n_total++; if (hazard_0 !== 1'b0) $display("FAIL rst_hazard got=%b want=0", hazard_0); else n_pass++;
        n_total++; if ({vec_0, out_pc_0, out_inst_0} !== '0)
            $display("FAIL rst_bundle got=%h want=0", {vec_0, out_pc_0, out_inst_0}); else n_pass++;
        rst = 1'b0;
        tick();
        n_total++; if (in_ready_0 !== 1'b1) $display("FAIL post_rst_in_ready got=%b want=1", in_ready_0); else n_pass++;
    endtask

    task automatic test_addi();
        in_valid = 1; in_inst = 32'h00300293; in_pc = 32'h100; out_ready = 1;
        tick();
        in_valid = 0;
        #1;
        n_total++; if (out_valid_0 !== 1'b1) $display("FAIL addi_valid got=%b want=1", out_valid_0); else n_pass++;
        n_total++; if ({rd_0, reg_write_0, alu_op_0, has_imm_0, imm_type_0, pc_sel_0} !== {5'd5, 1'b1, 5'h00, 1'b1, 3'd0, 2'd0})
            $display("FAIL addi_fields got=%h want=%h", {rd_0, reg_write_0, alu_op_0, has_imm_0, imm_type_0, pc_sel_0},
                     {5'd5, 1'b1, 5'h00, 1'b1, 3'd0, 2'd0}); else n_pass++;
        n_total++; if (out_pc_0 !== 32'h100) $display("FAIL addi_pc got=%h want=100", out_pc_0); else n_pass++;
        tick();
        n_total++; if (out_valid_0 !== 1'b0) $display("FAIL addi_drain got=%b want=0", out_valid_0); else n_pass++;
    endtask

    task automatic test_back_to_back();
        out_ready = 0; in_valid = 1; in_inst = 32'h00100093; in_pc = 32'h200;
        #1;
        n_total++; if (in_ready_0 !== 1'b1) $display("FAIL b2b_ready_a got=%b want=1", in_ready_0); else n_pass++;
        tick();
        in_inst = 32'h00200113; in_pc = 32'h204;
        #1;
        n_total++; if (in_ready_0 !== 1'b1) $display("FAIL b2b_ready_b got=%b want=1", in_ready_0); else n_pass++;
        tick();
        in_inst = 32'h00300193; in_pc = 32'h208;
        #1;
        n_total++; if (in_ready_0 !== 1'b0) $display("FAIL b2b_ready_c got=%b want=0", in_ready_0); else n_pass++;
        tick();
        n_total++; if ({in_ready_0, out_valid_0, out_inst_0} !== {1'b0, 1'b1, 32'h00100093})
            $display("FAIL b2b_stall got=%b/%b/%h want=0/1/00100093", in_ready_0, out_valid_0, out_inst_0); else n_pass++;
        out_ready = 1;
        #1;
        n_total++; if ({out_valid_0, out_inst_0} !== {1'b1, 32'h00100093})
            $display("FAIL b2b_out_a got=%b/%h want=1/00100093", out_valid_0, out_inst_0); else n_pass++;
        tick();
        n_total++; if ({out_valid_0, out_inst_0} !== {1'b1, 32'h00200113})
            $display("FAIL b2b_out_b got=%b/%h want=1/00200113", out_valid_0, out_inst_0); else n_pass++;
        tick();
        in_valid = 0;
        #1;
        n_total++; if ({out_valid_0, out_inst_0, out_pc_0} !== {1'b1, 32'h00300193, 32'h208})
            $display("FAIL b2b_out_c got=%b/%h/%h want=1/00300193/208", out_valid_0, out_inst_0, out_pc_0); else n_pass++;
        tick();
        n_total++; if (out_valid_0 !== 1'b0) $display("FAIL b2b_empty got=%b want=0", out_valid_0); else n_pass++;
    endtask

    task automatic test_hazard();
        out_ready = 0; in_valid = 1; in_inst = 32'h002081B3; in_pc = 32'h300;
        tick();
        in_valid = 0; ex_load_valid = 1; ex_load_rd = 5'd2;
        #1;
        n_total++; if ({hazard_0, out_valid_0} !== 2'b10) $display("FAIL haz_rs2 got=%b%b want=10", hazard_0, out_valid_0); else n_pass++;
        ex_load_rd = 5'd1;
        #1;
        n_total++; if ({hazard_0, out_valid_0} !== 2'b10) $display("FAIL haz_rs1 got=%b%b want=10", hazard_0, out_valid_0); else n_pass++;
        ex_load_rd = 5'd0;
        #1;
        n_total++; if ({hazard_0, out_valid_0} !== 2'b01) $display("FAIL haz_x0 got=%b%b want=01", hazard_0, out_valid_0); else n_pass++;
        ex_load_rd = 5'd3;
        #1;
        n_total++; if ({hazard_0, out_valid_0} !== 2'b01) $display("FAIL haz_other got=%b%b want=01", hazard_0, out_valid_0); else n_pass++;
        ex_load_rd = 5'd2; out_ready = 1;
        tick();
        n_total++; if ({out_valid_0, out_inst_0} !== {1'b0, 32'h002081B3})
            $display("FAIL haz_hold got=%b/%h want=0/002081b3", out_valid_0, out_inst_0); else n_pass++;
        ex_load_valid = 0;
        #1;
        n_total++; if (out_valid_0 !== 1'b1) $display("FAIL haz_release got=%b want=1", out_valid_0); else n_pass++;
        tick();
    endtask

    task automatic test_flush();
        out_ready = 0; in_valid = 1; in_inst = 32'h00100093;
        tick();
        in_inst = 32'h00200113;
        tick();
        in_inst = 32'h00300193; flush = 1;
        tick();
        flush = 0; in_valid = 0;
        #1;
        n_total++; if ({out_valid_0, in_ready_0} !== 2'b01) $display("FAIL flush_full got=%b%b want=01", out_valid_0, in_ready_0); else n_pass++;
        out_ready = 1; in_valid = 1; in_inst = 32'h00100093;
        tick();
        in_inst = 32'h00500293; flush = 1;
        tick();
        flush = 0; in_valid = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_total++; if (out_valid_0 !== 1'b0) $display("FAIL flush_discard got=%b want=0", out_valid_0); else n_pass++;
            tick();
        end
    endtask

    task automatic test_mext();
        out_ready = 1; in_valid = 1; in_inst = 32'h02208133;
        tick();
        in_valid = 0;
        #1;
        n_total++; if ({illegal_0, reg_write_0} !== 2'b10) $display("FAIL mul_m0 got=%b%b want=10", illegal_0, reg_write_0); else n_pass++;
        n_total++; if ({illegal_1, reg_write_1, alu_op_1} !== {2'b01, 5'h11})
            $display("FAIL mul_m1 got=%b%b/%h want=01/11", illegal_1, reg_write_1, alu_op_1); else n_pass++;
        tick();
    endtask

    task automatic test_branch_illegal();
        out_ready = 1; in_valid = 1; in_inst = 32'h0020C463;
        tick();
        in_inst = 32'h0000207F;
        #1;
        n_total++; if ({is_branch_0, br_cond_0, pc_sel_0, imm_type_0, reg_write_0, illegal_0} !== {1'b1, 3'b100, 2'd1, 3'd4, 1'b0, 1'b0})
            $display("FAIL blt got=%b/%b/%0d/%0d/%b/%b want=1/100/1/4/0/0", is_branch_0, br_cond_0, pc_sel_0,
                     imm_type_0, reg_write_0, illegal_0); else n_pass++;
        tick();
        in_valid = 0;
        #1;
        n_total++; if ({illegal_0, reg_write_0, mem_read_0, mem_write_0} !== 4'b1000)
            $display("FAIL bad_opcode got=%b%b%b%b want=1000", illegal_0, reg_write_0, mem_read_0, mem_write_0); else n_pass++;
        tick();
    endtask

    typedef struct packed { logic [31:0] pc; logic [31:0] inst; } ent_t;

    task automatic test_random();
        ent_t q[$];
        ent_t e;
        bit e_ready, e_haz, e_valid;
        for (int c = 0; c < 800; c++) begin
            flush = ($urandom_range(0, 39) == 0);
            in_valid = ($urandom_range(0, 2) != 0);
            in_inst = gen_inst();
            in_pc = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            ex_load_valid = ($urandom_range(0, 2) == 0);
            ex_load_rd = 5'($urandom_range(0, 7));
            #1;
            e_ready = (q.size() < 2);
            e_haz = 0;
            if (q.size() > 0 && ex_load_valid && ex_load_rd != 0)
                e_haz = (uses_rs1(q[0].inst) && q[0].inst[19:15] == ex_load_rd) ||
                        (uses_rs2(q[0].inst) && q[0].inst[24:20] == ex_load_rd);
            e_valid = (q.size() > 0) && !e_haz;
            n_total++; if ({in_ready_0, in_ready_1} !== {e_ready, e_ready})
                $display("FAIL rnd_in_ready c=%0d got=%b%b want=%b", c, in_ready_0, in_ready_1, e_ready); else n_pass++;
            n_total++; if ({hazard_0, hazard_1} !== {e_haz, e_haz})
                $display("FAIL rnd_hazard c=%0d got=%b%b want=%b", c, hazard_0, hazard_1, e_haz); else n_pass++;
            n_total++; if ({out_valid_0, out_valid_1} !== {e_valid, e_valid})
                $display("FAIL rnd_out_valid c=%0d got=%b%b want=%b", c, out_valid_0, out_valid_1, e_valid); else n_pass++;
            if (e_valid) begin
                n_total++; if ({out_pc_0, out_inst_0} !== {q[0].pc, q[0].inst})
                    $display("FAIL rnd_order c=%0d got=%h/%h want=%h/%h", c, out_pc_0, out_inst_0, q[0].pc, q[0].inst); else n_pass++;
                n_total++; if (vec_0 !== model(q[0].inst, 0))
                    $display("FAIL rnd_dec_m0 inst=%h got=%h want=%h", q[0].inst, vec_0, model(q[0].inst, 0)); else n_pass++;
                n_total++; if (vec_1 !== model(q[0].inst, 1))
                    $display("FAIL rnd_dec_m1 inst=%h got=%h want=%h", q[0].inst, vec_1, model(q[0].inst, 1)); else n_pass++;
            end
            if (flush) q.delete();
            else begin
                if (e_valid && out_ready) void'(q.pop_front());
                if (in_valid && e_ready) begin
                    e.pc = in_pc; e.inst = in_inst;
                    q.push_back(e);
                end
            end
            tick();
        end
        flush = 0; in_valid = 0; ex_load_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_hazard();
        test_flush();
        test_mext();
        test_branch_illegal();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
